qos_sched: RTL and testbench



---
 rtl/qos_pkg.sv | 7 +
 rtl/qos_rr_pick.sv | 25 ++
 rtl/qos_sched.sv | 83 ++++++++
 tb/tb_qos_sched.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/qos_pkg.sv
// qos_pkg: shared defaults and scheduler state encoding for the QoS scheduler.
package qos_pkg;
  localparam int DEF_QOS_CLASS_TYPE = 4;
  localparam int DEF_CREDIT_W = 4;
  localparam int DEF_CLS_W = $clog2(DEF_QOS_CLASS_TYPE);
  typedef enum logic [1:0] {RELOAD, IDLE, GRANT} state_t;
endpackage

// File: rtl/qos_rr_pick.sv
// qos_rr_pick: combinational rotating-priority picker starting at ptr.
module qos_rr_pick import qos_pkg::*; #(
  parameter int N = DEF_QOS_CLASS_TYPE
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx,
  output logic [N-1:0]         onehot
);
  localparam int CW = $clog2(N);
  always_comb begin
    int j;
    j = 0;
    found = |req;
    idx = '0;
    // scan farthest-first so the request nearest ptr overwrites the rest
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) idx = CW'(j);
    end
    onehot = found ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/qos_sched.sv
// qos_sched: weighted round-robin class scheduler with credit reload on exhaustion.
module qos_sched import qos_pkg::*; #(
  parameter int QOS_CLASS_TYPE = DEF_QOS_CLASS_TYPE,
  parameter int CREDIT_W = DEF_CREDIT_W
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                clean,
  input  logic [QOS_CLASS_TYPE-1:0]           type_flag,
  input  logic [QOS_CLASS_TYPE*CREDIT_W-1:0]  weight_cfg,
  output logic                                grant_valid,
  input  logic                                grant_ready,
  output logic [$clog2(QOS_CLASS_TYPE)-1:0]   grant_class,
  output logic [QOS_CLASS_TYPE-1:0]           grant_onehot,
  output logic                                round_done
);
  localparam int CW = $clog2(QOS_CLASS_TYPE);
  state_t state;
  logic [CREDIT_W-1:0] credit [QOS_CLASS_TYPE];
  logic [CW-1:0] rr_ptr, pick_idx, nxt_ptr;
  logic [QOS_CLASS_TYPE-1:0] eligible, enabled, pick_onehot;
  logic found;
  for (genvar i = 0; i < QOS_CLASS_TYPE; i++) begin : g_cls
    assign eligible[i] = type_flag[i] && (credit[i] != '0);
    assign enabled[i] = weight_cfg[i*CREDIT_W +: CREDIT_W] != '0;
  end
  assign nxt_ptr = (grant_class == CW'(QOS_CLASS_TYPE - 1)) ? '0 : grant_class + 1'b1;
  qos_rr_pick #(.N(QOS_CLASS_TYPE)) u_pick (
    .req(eligible),
    .ptr(rr_ptr),
    .found(found),
    .idx(pick_idx),
    .onehot(pick_onehot)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RELOAD;
      rr_ptr <= '0;
      grant_valid <= 1'b0;
      grant_class <= '0;
      grant_onehot <= '0;
      round_done <= 1'b0;
      for (int i = 0; i < QOS_CLASS_TYPE; i++) credit[i] <= '0;
    end else if (clean) begin
      state <= RELOAD;
      rr_ptr <= '0;
      grant_valid <= 1'b0;
      grant_class <= '0;
      grant_onehot <= '0;
      round_done <= 1'b0;
      for (int i = 0; i < QOS_CLASS_TYPE; i++) credit[i] <= '0;
    end else begin
      round_done <= 1'b0;
      case (state)
        RELOAD: begin
          for (int i = 0; i < QOS_CLASS_TYPE; i++) credit[i] <= weight_cfg[i*CREDIT_W +: CREDIT_W];
          state <= IDLE;
        end
        IDLE: begin
          if (found) begin
            grant_valid <= 1'b1;
            grant_class <= pick_idx;
            grant_onehot <= pick_onehot;
            state <= GRANT;
          end else if (|(type_flag & enabled)) begin
            round_done <= 1'b1;
            state <= RELOAD;
          end
        end
        GRANT: begin
          if (grant_ready) begin
            credit[grant_class] <= credit[grant_class] - 1'b1;
            rr_ptr <= nxt_ptr;
            grant_valid <= 1'b0;
            grant_onehot <= '0;
            state <= IDLE;
          end
        end
        default: state <= RELOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_qos_sched.sv
// tb_qos_sched: vector table plus corner sequences, grants checked against an expected-class queue.
module tb_qos_sched;
  logic clk = 1'b0, rst_n = 1'b0, clean = 1'b0, grant_ready = 1'b0;
  logic [3:0] type_flag = '0;
  logic [15:0] weight_cfg = '0;
  logic grant_valid, round_done;
  logic [1:0] grant_class;
  logic [3:0] grant_onehot;
  int n_chk = 0, n_fail = 0, rd_cnt = 0, v_cnt = 0, e;
  int exp_q[$];
  bit prev_acc = 0, acc;
  typedef struct {
    logic [15:0] w;
    logic [3:0]  flag;
    int          n;
    logic [31:0] seq;
    int          rd;
  } vec_t;
  vec_t vt[4];

  qos_sched dut (
    .clk(clk), .rst_n(rst_n), .clean(clean), .type_flag(type_flag),
    .weight_cfg(weight_cfg), .grant_valid(grant_valid), .grant_ready(grant_ready),
    .grant_class(grant_class), .grant_onehot(grant_onehot), .round_done(round_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (prev_acc) chk("gap_after_accept", grant_valid, 0);
    if (!grant_valid) chk("onehot_idle", grant_onehot, 0);
    if (round_done) rd_cnt++;
    if (grant_valid) v_cnt++;
    acc = grant_valid && grant_ready && !clean && rst_n;
    if (acc) begin
      if (exp_q.size() == 0) chk("unexpected_grant", grant_class, -1);
      else begin
        e = exp_q.pop_front();
        chk("grant_class", grant_class, e);
        chk("grant_onehot", grant_onehot, 1 << e);
      end
    end
    prev_acc = acc;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clean();
    grant_ready = 1'b0;
    clean = 1'b1;
    tick();
    clean = 1'b0;
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      tick();
      c++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_valid(input int budget);
    int c = 0;
    while (!grant_valid && c < budget) begin
      tick();
      c++;
    end
    chk("wait_valid", grant_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // grant order is read from nibble 0 upward
    vt[0] = '{16'h1111, 4'b0101, 6, 32'h00202020, 2};
    vt[1] = '{16'h0013, 4'b0011, 8, 32'h00010010, 1};
    vt[2] = '{16'h1102, 4'b1111, 8, 32'h00320320, 1};
    vt[3] = '{16'h2111, 4'b1010, 6, 32'h00331331, 1};

    // reset values and first-grant latency
    weight_cfg = 16'h1111;
    type_flag = 4'b0001;
    tick();
    tick();
    chk("rst_valid", grant_valid, 0);
    chk("rst_class", grant_class, 0);
    chk("rst_onehot", grant_onehot, 0);
    chk("rst_round_done", round_done, 0);
    rst_n = 1'b1;
    tick();
    chk("cycle1_valid", grant_valid, 0);
    tick();
    chk("cycle2_valid", grant_valid, 1);
    chk("cycle2_class", grant_class, 0);
    chk("cycle2_onehot", grant_onehot, 1);

    foreach (vt[v]) begin
      do_clean();
      weight_cfg = vt[v].w;
      type_flag = vt[v].flag;
      rd_cnt = 0;
      for (int k = 0; k < vt[v].n; k++) exp_q.push_back(int'(vt[v].seq[k*4 +: 4]));
      grant_ready = 1'b1;
      drain(200);
      chk($sformatf("vec%0d_round_done", v), rd_cnt, vt[v].rd);
    end

    // backpressure on a class-2 grant; no credit charge while stalled
    do_clean();
    weight_cfg = 16'h0211;
    type_flag = 4'b0100;
    rd_cnt = 0;
    wait_valid(10);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_valid", grant_valid, 1);
      chk("stall_class", grant_class, 2);
      chk("stall_onehot", grant_onehot, 4'b0100);
    end
    exp_q.push_back(2);
    exp_q.push_back(2);
    grant_ready = 1'b1;
    drain(50);
    chk("stall_no_early_reload", rd_cnt, 0);
    tick();
    tick();
    chk("stall_reload_after_two", rd_cnt, 1);

    // pending but disabled class never granted, never reloads
    do_clean();
    weight_cfg = 16'h0111;
    type_flag = 4'b1000;
    grant_ready = 1'b1;
    rd_cnt = 0;
    v_cnt = 0;
    repeat (12) tick();
    chk("disabled_valid_cnt", v_cnt, 0);
    chk("disabled_round_done", rd_cnt, 0);

    // clean beats grant_ready on a class-1 grant
    do_clean();
    weight_cfg = 16'h1111;
    type_flag = 4'b0010;
    wait_valid(10);
    chk("clean_pre_class", grant_class, 1);
    clean = 1'b1;
    grant_ready = 1'b1;
    tick();
    clean = 1'b0;
    grant_ready = 1'b0;
    type_flag = 4'b0011;
    chk("clean_valid", grant_valid, 0);
    chk("clean_onehot", grant_onehot, 0);
    tick();
    chk("clean_reload_valid", grant_valid, 0);
    tick();
    chk("clean_next_valid", grant_valid, 1);
    chk("clean_next_class", grant_class, 0);
    exp_q.push_back(0);
    exp_q.push_back(1);
    grant_ready = 1'b1;
    drain(50);

    // async reset mid-grant, then new weights take effect
    do_clean();
    weight_cfg = 16'h1111;
    type_flag = 4'b0100;
    wait_valid(10);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", grant_valid, 0);
    chk("arst_onehot", grant_onehot, 0);
    chk("arst_class", grant_class, 0);
    weight_cfg = 16'h0300;
    tick();
    rst_n = 1'b1;
    rd_cnt = 0;
    exp_q.push_back(2);
    exp_q.push_back(2);
    exp_q.push_back(2);
    grant_ready = 1'b1;
    tick();
    chk("arst_cycle1_valid", grant_valid, 0);
    tick();
    chk("arst_cycle2_valid", grant_valid, 1);
    chk("arst_cycle2_class", grant_class, 2);
    drain(50);
    chk("arst_no_early_reload", rd_cnt, 0);
    tick();
    tick();
    chk("arst_reload_after_three", rd_cnt, 1);
    do_clean();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
